draw_point_arbiter: RTL and testbench
=====================================

# draw_point_arbiter

Shares the single draw-point (frame transfer) bus feeding the VGA driver between two writers: the CPU command path (Avalon burst writes decoded into points) and the camera pixel stream. Burst-granular round-robin arbitration, registered output stage with back-pressure, and off-screen point filtering. Sits in the command clock domain between the Avalon command slave / camera capture and the VGA driver's draw-point input.

## Interface
- H_ACTIVE, 640: visible columns; points with x >= H_ACTIVE are filtered
- V_ACTIVE, 480: visible rows; points with y >= V_ACTIVE are filtered
- MAX_BURST, 640: max beats per grant before forced re-arbitration (1..1023)
- csi_clock_clk  in  1  command clock; all logic on rising edge
- rsi_reset_reset  in  1  reset, asynchronous, active-high
- asi_cpu_valid / asi_cam_valid  in  1  requester point valid
- asi_cpu_ready / asi_cam_ready  out  1  requester point accepted this cycle when valid&ready
- asi_cpu_x / asi_cam_x  in  10  column
- asi_cpu_y / asi_cam_y  in  9  row
- asi_cpu_rgb / asi_cam_rgb  in  24  {R,G,B} 8 bits each
- asi_cpu_last / asi_cam_last  in  1  final beat of requester burst
- aso_draw_valid  out  1  point valid to VGA driver
- aso_draw_ready  in  1  driver accepts point
- aso_draw_x  out  10, aso_draw_y  out  9, aso_draw_rgb  out  24  point data
- aso_draw_src  out  1  0 = CPU, 1 = camera
- sts_cpu_count, sts_cam_count, sts_drop_count  out  32 each  statistics (see Configuration)

## Operation
- States: IDLE, GNT_CPU, GNT_CAM.
- IDLE: if exactly one valid, grant it; if both, grant the one not served last (rr pointer; reset value favours CPU). No valid: stay. Transition registered; one bubble cycle per arbitration.
- GNT_x: asi_x_ready = !aso_draw_valid | aso_draw_ready; other requester ready = 0. Beat counter (10 bits) increments per accepted beat.
- Release to IDLE after accepting a beat with last=1, or the MAX_BURST-th beat, whichever first; rr pointer set to the served requester; counter cleared.
- Valid deasserted mid-burst: grant held, no timeout.
- Accepted beat in range: loaded into output register with src. Off-screen beat (x >= H_ACTIVE or y >= V_ACTIVE): accepted, not forwarded, counts toward burst length and last.
- Output register holds data stable while aso_draw_valid & !aso_draw_ready.

## Timing
- Reset: state IDLE, rr favours CPU, both asi_*_ready 0, aso_draw_valid 0, aso_draw_x/y/rgb/src 0, counters 0.
- Latency: accepted beat appears on aso_draw_* next cycle.
- Full throughput: one point/cycle within a burst while aso_draw_ready = 1.
- Arbitration overhead: exactly one cycle in IDLE between bursts (none if no requester valid).
- Simultaneous last-beat accept and output stall: beat is taken, state goes IDLE; output waits for ready.
- Reset mid-burst: output point in flight is discarded; requesters must restart bursts.

## Configuration
- DRAW_POINT_ARBITER_STATS_EN defined: sts_cpu_count / sts_cam_count increment per forwarded point of that source; sts_drop_count per filtered point; all wrap at 2^32.
- Undefined: no counter logic; sts_* tied to 0.

## Structure
- Shared package: state enum, point struct {x[9:0], y[8:0], rgb[23:0]}, source enum, default H_ACTIVE/V_ACTIVE constants (shared with VGA driver).
- One sub-module: draw_point_out_reg (valid/ready output register with data hold).

## Test plan
- CPU-only burst of 4 points (0,0)…(3,0), last on 4th, draw_ready=1 -> 4 outputs src=0 in consecutive cycles, one cycle after each accept.
- Both valid from reset, each 2-beat bursts repeated -> grant order CPU, CAM, CPU, CAM with one idle cycle between bursts.
- MAX_BURST=4, camera streams 10 beats no last while CPU valid -> CAM 4 beats, CPU burst, CAM resumes.
- Point (640,10) and (5,480) in CPU burst -> not forwarded, asi_cpu_ready still 1; with stats macro sts_drop_count = 2.
- draw_ready low 3 cycles mid-burst -> aso_draw_* stable, requester ready 0 until release, no loss/duplication.
- Reset asserted mid-burst asynchronously -> all outputs 0 immediately, next grant goes to CPU.

Source files
------------

// File: rtl/draw_point_arbiter_pkg.sv
// Shared draw-point types: point/beat structs, source encoding, FSM codes, screen size.
// Screen constants are also used by the VGA driver so both agree on the visible area.
package draw_point_arbiter_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GNT_CPU = 2'd1;
  localparam logic [1:0] ST_GNT_CAM = 2'd2;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_CAM = 1'b1
  } src_e;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
  } point_t;

  typedef struct packed {
    src_e   src;
    point_t pt;
  } out_beat_t;

  function automatic logic on_screen(input point_t p, input int h_active, input int v_active);
    return (32'(p.x) < h_active) && (32'(p.y) < v_active);
  endfunction

endpackage

// File: rtl/draw_point_arbiter_if.sv
// Draw-point stream interfaces: requester side carries burst 'last', driver side carries source tag.
// Transfer happens on a cycle where valid and ready are both high.
interface draw_point_req_if;
  import draw_point_arbiter_pkg::*;

  logic   valid;
  logic   ready;
  point_t pt;
  logic   last;

  modport master (output valid, pt, last, input ready);
  modport slave  (input valid, pt, last, output ready);
endinterface

interface draw_point_out_if;
  import draw_point_arbiter_pkg::*;

  logic   valid;
  logic   ready;
  point_t pt;
  src_e   src;

  modport master (output valid, pt, src, input ready);
  modport slave  (input valid, pt, src, output ready);
endinterface

// File: rtl/draw_point_out_reg.sv
// Single-entry valid/ready output register: data appears one cycle after load, held while stalled.
// in_rdy is high when the register is empty or being drained this cycle.
module draw_point_out_reg
  import draw_point_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_vld,
  input  out_beat_t in_dat,
  output logic      in_rdy,
  output logic      out_vld,
  output out_beat_t out_dat,
  input  logic      out_rdy
);

  logic      vld_q, vld_d;
  out_beat_t dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/draw_point_arbiter.sv
// Burst round-robin arbiter (CPU/camera) onto the draw-point bus; beat visible 1 cycle after accept,
// requester ready follows the output register. Optional statistics: DRAW_POINT_ARBITER_STATS_EN.
module draw_point_arbiter
  import draw_point_arbiter_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int MAX_BURST = 640
) (
  input  logic             csi_clock_clk,
  input  logic             rsi_reset_reset,
  draw_point_req_if.slave  asi_cpu,
  draw_point_req_if.slave  asi_cam,
  draw_point_out_if.master aso_draw,
  output logic [31:0]      sts_cpu_count,
  output logic [31:0]      sts_cam_count,
  output logic [31:0]      sts_drop_count
);

  logic [1:0] state_q, state_d;
  src_e       rr_q, rr_d;
  logic [9:0] beat_cnt_q, beat_cnt_d;

  logic      out_in_rdy;
  logic      sel_vld, sel_last, acc, fwd, burst_end;
  point_t    sel_pt;
  src_e      sel_src;
  out_beat_t out_dat;

  always_comb begin
    sel_vld       = 1'b0;
    sel_pt        = asi_cpu.pt;
    sel_last      = asi_cpu.last;
    sel_src       = SRC_CPU;
    asi_cpu.ready = 1'b0;
    asi_cam.ready = 1'b0;
    case (state_q)
      ST_GNT_CPU: begin
        sel_vld       = asi_cpu.valid;
        asi_cpu.ready = out_in_rdy;
      end
      ST_GNT_CAM: begin
        sel_vld       = asi_cam.valid;
        sel_pt        = asi_cam.pt;
        sel_last      = asi_cam.last;
        sel_src       = SRC_CAM;
        asi_cam.ready = out_in_rdy;
      end
      default: ;
    endcase
  end

  // Off-screen beats are consumed and counted toward the burst, but never reach the driver.
  assign acc       = sel_vld && out_in_rdy;
  assign fwd       = acc && on_screen(sel_pt, H_ACTIVE, V_ACTIVE);
  assign burst_end = acc && (sel_last || (beat_cnt_q == 10'(MAX_BURST - 1)));

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // rr_q holds the last source served; on a tie the other one wins.
        if (asi_cpu.valid && (!asi_cam.valid || rr_q == SRC_CAM)) begin
          state_d = ST_GNT_CPU;
        end else if (asi_cam.valid) begin
          state_d = ST_GNT_CAM;
        end
      end
      ST_GNT_CPU, ST_GNT_CAM: begin
        if (burst_end) begin
          state_d    = ST_IDLE;
          rr_d       = sel_src;
          beat_cnt_d = '0;
        end else if (acc) begin
          beat_cnt_d = beat_cnt_q + 10'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= SRC_CAM;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  draw_point_out_reg u_out_reg (
    .clk     (csi_clock_clk),
    .rst     (rsi_reset_reset),
    .in_vld  (fwd),
    .in_dat  ('{src: sel_src, pt: sel_pt}),
    .in_rdy  (out_in_rdy),
    .out_vld (aso_draw.valid),
    .out_dat (out_dat),
    .out_rdy (aso_draw.ready)
  );

  assign aso_draw.pt  = out_dat.pt;
  assign aso_draw.src = out_dat.src;

`ifdef DRAW_POINT_ARBITER_STATS_EN
  logic        drop;
  logic [31:0] cpu_cnt_q, cpu_cnt_d, cam_cnt_q, cam_cnt_d, drop_cnt_q, drop_cnt_d;

  assign drop = acc && !fwd;

  always_comb begin
    cpu_cnt_d  = cpu_cnt_q;
    cam_cnt_d  = cam_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (fwd && sel_src == SRC_CPU) cpu_cnt_d = cpu_cnt_q + 32'd1;
    if (fwd && sel_src == SRC_CAM) cam_cnt_d = cam_cnt_q + 32'd1;
    if (drop) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge csi_clock_clk or posedge rsi_reset_reset) begin
    if (rsi_reset_reset) begin
      cpu_cnt_q  <= '0;
      cam_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      cpu_cnt_q  <= cpu_cnt_d;
      cam_cnt_q  <= cam_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign sts_cpu_count  = cpu_cnt_q;
  assign sts_cam_count  = cam_cnt_q;
  assign sts_drop_count = drop_cnt_q;
`else
  assign sts_cpu_count  = '0;
  assign sts_cam_count  = '0;
  assign sts_drop_count = '0;
`endif

endmodule

// File: tb/tb_draw_point_arbiter.sv
// Directed bench for draw_point_arbiter (MAX_BURST=4): bursts, round-robin, filtering, stall, reset.
module tb_draw_point_arbiter;
  import draw_point_arbiter_pkg::*;

  typedef struct {int x; int y; logic [23:0] rgb; bit last;} beat_t;
  typedef struct {int cyc; int src; int x; int y; logic [23:0] rgb;} ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] sts_cpu, sts_cam, sts_drop;

  draw_point_req_if cpu_if ();
  draw_point_req_if cam_if ();
  draw_point_out_if draw_if ();

  draw_point_arbiter #(.H_ACTIVE(640), .V_ACTIVE(480), .MAX_BURST(4)) dut (
    .csi_clock_clk   (clk),
    .rsi_reset_reset (rst),
    .asi_cpu         (cpu_if),
    .asi_cam         (cam_if),
    .aso_draw        (draw_if),
    .sts_cpu_count   (sts_cpu),
    .sts_cam_count   (sts_cam),
    .sts_drop_count  (sts_drop)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  beat_t cpu_q[$], cam_q[$];
  ent_t  out_log[$];
  int    cpu_acc_cyc[$];

  int t3_x[12] = '{100, 101, 102, 103, 50, 51, 104, 105, 106, 107, 108, 109};
  int t3_s[12] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
  int t2_x[8]  = '{10, 11, 20, 21, 12, 13, 22, 23};
  int t2_s[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic push(input bit cam, input int x, input int y, input bit last);
    beat_t b;
    b.x = x; b.y = y; b.rgb = 24'(x * 7 + y); b.last = last;
    if (cam) cam_q.push_back(b);
    else     cpu_q.push_back(b);
  endtask

  function automatic int ox(input int i);
    if (i < out_log.size()) return out_log[i].x;
    return -1;
  endfunction
  function automatic int os(input int i);
    if (i < out_log.size()) return out_log[i].src;
    return -1;
  endfunction
  function automatic int oc(input int i);
    if (i < out_log.size()) return out_log[i].cyc;
    return -1;
  endfunction

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_out(input string tag, input int n);
    int k = 0;
    while (out_log.size() < n && k < 300) begin step(); k++; end
    repeat (3) step();
    chk(tag, out_log.size(), n);
  endtask

  // Requester drivers and output monitor: sample at negedge, update drives just after posedge.
  initial begin
    bit acc_c, acc_m;
    cpu_if.valid = 0; cpu_if.pt = '0; cpu_if.last = 0;
    cam_if.valid = 0; cam_if.pt = '0; cam_if.last = 0;
    forever begin
      @(negedge clk);
      acc_c = !rst && cpu_if.valid && cpu_if.ready;
      acc_m = !rst && cam_if.valid && cam_if.ready;
      if (acc_c) cpu_acc_cyc.push_back(cyc);
      if (!rst && draw_if.valid && draw_if.ready)
        out_log.push_back('{cyc, int'(draw_if.src), int'(draw_if.pt.x), int'(draw_if.pt.y), draw_if.pt.rgb});
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        cpu_if.valid = 0;
        cam_if.valid = 0;
      end else begin
        if (acc_c && cpu_q.size() > 0) void'(cpu_q.pop_front());
        if (acc_m && cam_q.size() > 0) void'(cam_q.pop_front());
        cpu_if.valid = cpu_q.size() > 0;
        if (cpu_q.size() > 0) begin
          cpu_if.pt   = '{x: 10'(cpu_q[0].x), y: 9'(cpu_q[0].y), rgb: cpu_q[0].rgb};
          cpu_if.last = cpu_q[0].last;
        end
        cam_if.valid = cam_q.size() > 0;
        if (cam_q.size() > 0) begin
          cam_if.pt   = '{x: 10'(cam_q[0].x), y: 9'(cam_q[0].y), rgb: cam_q[0].rgb};
          cam_if.last = cam_q[0].last;
        end
      end
    end
  end

  initial begin
    draw_if.ready = 1'b1;
    repeat (2) step();

    // Reset values
    chk("rst_valid", draw_if.valid, 0);
    chk("rst_x", draw_if.pt.x, 0);
    chk("rst_y", draw_if.pt.y, 0);
    chk("rst_rgb", draw_if.pt.rgb, 0);
    chk("rst_src", draw_if.src, 0);
    chk("rst_cpu_rdy", cpu_if.ready, 0);
    chk("rst_cam_rdy", cam_if.ready, 0);
    chk("rst_sts_drop", sts_drop, 0);
    rst = 1'b0;

    // CPU-only 4-beat burst: back-to-back outputs one cycle after each accept
    out_log.delete(); cpu_acc_cyc.delete();
    for (int i = 0; i < 4; i++) push(0, i, 0, i == 3);
    wait_out("t1_count", 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_src", os(i), 0);
      chk("t1_x", ox(i), i);
      chk("t1_lat", oc(i) - ((i < cpu_acc_cyc.size()) ? cpu_acc_cyc[i] : -9), 1);
      chk("t1_b2b", oc(i) - oc(0), i);
    end
    if (out_log.size() > 3) chk("t1_rgb", out_log[3].rgb, 24'd21);

    // Both valid from reset, 2-beat bursts: CPU, CAM, CPU, CAM with one bubble between
    rst = 1'b1; step(); rst = 1'b0;
    out_log.delete();
    push(0, 10, 0, 0); push(0, 11, 0, 1); push(0, 12, 0, 0); push(0, 13, 0, 1);
    push(1, 20, 1, 0); push(1, 21, 1, 1); push(1, 22, 1, 0); push(1, 23, 1, 1);
    wait_out("t2_count", 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_src", os(i), t2_s[i]);
      chk("t2_x", ox(i), t2_x[i]);
    end
    chk("t2_gap1", oc(2) - oc(1), 2);
    chk("t2_gap2", oc(4) - oc(3), 2);
    chk("t2_inburst", oc(1) - oc(0), 1);

    // Camera streams 10 beats while CPU waits: MAX_BURST forces re-arbitration
    out_log.delete();
    for (int i = 0; i < 10; i++) push(1, 100 + i, 5, i == 9);
    step();
    push(0, 50, 7, 0); push(0, 51, 7, 1);
    wait_out("t3_count", 12);
    for (int i = 0; i < 12; i++) begin
      chk("t3_src", os(i), t3_s[i]);
      chk("t3_x", ox(i), t3_x[i]);
    end

    // Off-screen points are consumed without a stall and not forwarded
    out_log.delete(); cpu_acc_cyc.delete();
    push(0, 1, 1, 0); push(0, 640, 10, 0); push(0, 5, 480, 0); push(0, 2, 2, 1);
    wait_out("t4_count", 2);
    chk("t4_x0", ox(0), 1);
    chk("t4_x1", ox(1), 2);
    chk("t4_acc_n", cpu_acc_cyc.size(), 4);
    if (cpu_acc_cyc.size() == 4) chk("t4_acc_b2b", cpu_acc_cyc[3] - cpu_acc_cyc[0], 3);
`ifdef DRAW_POINT_ARBITER_STATS_EN
    chk("t4_sts_drop", sts_drop, 2);
    chk("t4_sts_cpu", sts_cpu, 8);
    chk("t4_sts_cam", sts_cam, 14);
`else
    chk("t4_sts_drop", sts_drop, 0);
    chk("t4_sts_cpu", sts_cpu, 0);
    chk("t4_sts_cam", sts_cam, 0);
`endif

    // Driver stalls 3 cycles mid-burst: point 32 held, requester not ready
    out_log.delete();
    for (int i = 0; i < 6; i++) push(0, 30 + i, 3, i == 5);
    for (int k = 0; k < 300 && out_log.size() < 2; k++) step();
    @(posedge clk); #1;
    draw_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_hold_vld", draw_if.valid, 1);
      chk("t5_hold_x", draw_if.pt.x, 32);
      chk("t5_cpu_rdy", cpu_if.ready, 0);
    end
    @(posedge clk); #1;
    draw_if.ready = 1'b1;
    wait_out("t5_count", 6);
    for (int i = 0; i < 6; i++) chk("t5_x", ox(i), 30 + i);

    // Asynchronous reset mid-burst clears outputs at once; CPU wins the next tie
    out_log.delete();
    for (int i = 0; i < 6; i++) push(0, 60 + i, 4, i == 5);
    for (int k = 0; k < 300 && out_log.size() < 2; k++) step();
    #2;
    rst = 1'b1;
    cpu_q.delete(); cam_q.delete();
    #1;
    chk("t6_vld", draw_if.valid, 0);
    chk("t6_x", draw_if.pt.x, 0);
    chk("t6_rgb", draw_if.pt.rgb, 0);
    chk("t6_cpu_rdy", cpu_if.ready, 0);
    step(); step();
    rst = 1'b0;
    out_log.delete();
    push(0, 80, 8, 0); push(0, 81, 8, 1);
    push(1, 90, 9, 0); push(1, 91, 9, 1);
    wait_out("t6_count", 4);
    chk("t6_first_src", os(0), 0);
    chk("t6_first_x", ox(0), 80);
    chk("t6_third_src", os(2), 1);
    chk("t6_third_x", ox(2), 90);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
